// File: rtl/mac_accumulator.sv
// Dot-product accumulate stage: sums len unsigned 16-bit products into an ACC_W-bit result.
// Build option: define MAC_ACC_SAT_EN to saturate on carry-out instead of wrapping.
module mac_accumulator #(
    parameter int ACC_W = 24,  // legal range 17..32
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [15:0]      p_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_p_ready;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_xfer;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;

    assign w_xfer     = p_valid && r_p_ready;
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - 16){1'b0}}, p_data};
    assign w_carry    = w_sum[ACC_W];
    assign w_ovf_next = r_ovf | w_carry;

`ifdef MAC_ACC_SAT_EN
    // Once saturated, any further carry (or a zero beat) keeps the all-ones value.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    // NOTE: state registers use non-blocking assignments so every update in this
    // block sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_p_ready   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_state   <= S_ACC;
                            r_cnt     <= len;
                            r_p_ready <= 1'b1;
                        end else begin
                            r_state     <= S_HOLD;
                            r_res_valid <= 1'b1;
                        end
                    end
                end

                S_ACC: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_next;
                        r_ovf <= w_ovf_next;
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state     <= S_HOLD;
                            r_p_ready   <= 1'b0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    // start is deliberately not looked at here, even on the accept cycle.
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_p_ready   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // The accumulator doubles as the result register; it only moves in ACC or on a new start.
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign p_ready   = r_p_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomised scoreboard bench for mac_accumulator at ACC_W=17 so wrap/saturation is reachable.
// Expected results come from a plain-arithmetic dot-product model; a monitor checks each accepted result.
module tb_mac_accumulator;

    localparam int ACC_W = 17;
    localparam int LEN_W = 8;
    localparam longint MAX_ACC = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             p_valid;
    logic             p_ready;
    logic [15:0]      p_data;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             busy;

    mac_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_data    (p_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dot product of the beats, then the overflow policy applied to the full-precision sum.
    function automatic exp_t model(input int unsigned beats[$]);
        exp_t   e;
        longint sum = 0;
        foreach (beats[i]) sum += longint'(beats[i]);
        e.ovf = (sum > MAX_ACC);
`ifdef MAC_ACC_SAT_EN
        e.data = e.ovf ? MAX_ACC : sum;
`else
        e.data = sum % (MAX_ACC + 1);
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_data", 64'(res_data), 64'(mon_e.data));
                check("res_ovf", 64'(res_ovf), 64'(mon_e.ovf));
            end
        end
    end

    // One full transaction; poke pulses start (len=9) during ACC and on the HOLD accept cycle.
    task automatic run(input int unsigned beats[$], input int gap, input bit rnd_gap,
                       input int hold, input bit poke);
        exp_t e;
        int   t;
        e = model(beats);
        sb_q.push_back(e);
        t = 0;
        while (busy && t < 50) begin
            step();
            t++;
        end
        check("idle_before_start", 64'(busy), 0);
        start = 1'b1;
        len   = LEN_W'(beats.size());
        step();
        start = 1'b0;
        foreach (beats[i]) begin
            repeat (rnd_gap ? $urandom_range(0, 2) : gap) begin
                p_valid = 1'b0;
                p_data  = 16'($urandom);
                step();
            end
            p_valid = 1'b1;
            p_data  = 16'(beats[i]);
            if (poke && i == 0) begin
                start = 1'b1;
                len   = LEN_W'(9);
            end
            t = 0;
            while (!p_ready && t < 10) begin
                step();
                t++;
            end
            if (!p_ready) begin
                check("p_ready_timeout", 0, 1);
                return;
            end
            step();
            p_valid = 1'b0;
            start   = 1'b0;
        end
        check("res_valid_latency", 64'(res_valid), 1);
        check("p_ready_after_last", 64'(p_ready), 0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_res_valid", 64'(res_valid), 1);
            check("hold_res_data", 64'(res_data), 64'(e.data));
        end
        res_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = LEN_W'(9);
        end
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        check("res_valid_drop", 64'(res_valid), 0);
        check("busy_after_accept", 64'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_ready"}, 64'(p_ready), 0);
        check({tag, "_res_valid"}, 64'(res_valid), 0);
        check({tag, "_res_data"}, 64'(res_data), 0);
        check({tag, "_res_ovf"}, 64'(res_ovf), 0);
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned q[$];
        rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0; res_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check_reset_outputs("idle");

        // Simple four-term sum, back-to-back beats.
        q = '{32'h0001, 32'h0002, 32'h0003, 32'h0004};
        run(q, 0, 1'b0, 0, 1'b0);

        // Gapped beats with a long hold.
        q = '{32'hFFFF, 32'h0010, 32'h0100};
        run(q, 2, 1'b0, 5, 1'b0);

        // Carry out of the 17-bit accumulator.
        q = '{32'hFFFF, 32'hFFFF, 32'hFFFF};
        run(q, 0, 1'b0, 1, 1'b0);

        // Empty vector: straight to HOLD with zero.
        q.delete();
        run(q, 0, 1'b0, 2, 1'b0);

        // Abort a len=5 run after two beats.
        start = 1'b1; len = LEN_W'(5);
        step();
        start = 1'b0;
        repeat (2) begin
            p_valid = 1'b1;
            p_data  = 16'h1234;
            step();
        end
        p_valid = 1'b0;
        rst = 1'b1;
        step();
        check_reset_outputs("abort");
        rst = 1'b0;
        step();
        q = '{32'h0007};
        run(q, 0, 1'b0, 0, 1'b0);

        // Spurious starts in ACC and HOLD are ignored.
        q = '{32'h0002, 32'h0003};
        run(q, 0, 1'b0, 1, 1'b1);
        step();
        check("busy_stays_idle", 64'(busy), 0);

        // Randomised transactions.
        for (int r = 0; r < 25; r++) begin
            int n;
            q.delete();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++)
                q.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 65535));
            run(q, 0, 1'b1, $urandom_range(0, 3), 1'(r % 5 == 0));
        end

        repeat (2) step();
        check("scoreboard_empty", 64'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
